window_3x3_gen: RTL and testbench
=================================

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 Parameter: IMG_W, default 640, pixels per line; legal range is 3..4096.
REQ-002 Parameter: IMG_H, default 480, lines per frame; legal range is 3..4096.
REQ-003 Port: clk  input  1  system clock; all logic is rising-edge.
REQ-004 Port: rst_n  input  1  reset; reset is asynchronous and active-low.
REQ-005 Port: pix_in  input  8  raster-order pixel, left to right and then top to bottom.
REQ-006 Port: pix_valid  input  1  pix_in is accepted on this clk edge.
REQ-007 Port: sof  input  1  start-of-frame marker, qualified as in REQ-016/017.
REQ-008 Port: p1..p9  output  8 each  3x3 window; p1..p3 are the top (oldest) row, p7..p9 the bottom (current) row, and p3/p6/p9 the rightmost (newest) column.
REQ-009 Port: din_flag  output  1  window on p1..p9 is valid this cycle; it drives the median filter's din_flag directly.
REQ-010 Port: eof  output  1  one-cycle pulse marking the last accepted pixel of a frame.

Function
REQ-011 Pixel counters:
- col counts 0..IMG_W-1 and row counts 0..IMG_H-1.
- col increments on each accepted pixel.
- When col=IMG_W-1, col wraps to 0 and row increments.
REQ-012 End of frame: an accepted pixel at col=IMG_W-1, row=IMG_H-1 sets col=0 and row=0.
REQ-013 Line buffers:
- There are two IMG_W-deep line buffers.
- On an accepted pixel at column c, the block reads line-1[c] and line-2[c] (rows r-1 and r-2).
- It then writes pix_in to line-1[c] and moves the old line-1[c] into line-2[c].
- Line-buffer contents are not reset.
REQ-014 Window shift: on each accepted pixel, every window row shifts left one column.
- p3 receives line-2[c].
- p6 receives line-1[c].
- p9 receives pix_in.
- All outputs are registered, with latency exactly 1 clk from the accepting edge.
REQ-015 Valid window:
- din_flag=1 on the cycle after an accepted pixel with row>=2 and col>=2; otherwise din_flag=0.
- Each frame yields exactly (IMG_W-2)*(IMG_H-2) din_flag pulses.
- Windows never span a line wrap.
REQ-016 sof with pix_valid=1: the pixel is treated as col=0, row=0, regardless of the counter state.
REQ-017 sof with pix_valid=0: col and row clear to 0; no buffer write, no shift, din_flag=0.
REQ-018 pix_valid=0: counters, buffers and window hold; din_flag=0; p1..p9 hold their last values.
REQ-019 eof: eof=1 on the cycle after the pixel that satisfies REQ-012; it coincides with the final din_flag of the frame.
REQ-020 Throughput: the block accepts one pixel per clk indefinitely and never back-pressures.

Reset
REQ-021 While rst_n=0:
- p1..p9=0, din_flag=0, eof=0.
- col=0, row=0.
- These take effect immediately, independent of clk.
REQ-022 Reset deassertion mid-frame: the next accepted pixel is treated as col=0, row=0; stale line-buffer data never raises din_flag, because row<2 for the first two lines.

Verification
REQ-023 Reference case:
- Setup: IMG_W=5, IMG_H=4, pix_in=row*16+col, continuous pix_valid, sof with the first pixel.
- Response: exactly 6 din_flag pulses.
- First window: p1..p9 = 00,01,02,10,11,12,20,21,22.
- Last window: 12,13,14,22,23,24,32,33,34, with eof=1 on that same cycle.
REQ-024 Same frame with pix_valid deasserted every other cycle: identical window sequence; din_flag never high on the cycle after pix_valid=0.
REQ-025 Two back-to-back frames with no idle cycle: 12 pulses in total; the first window of frame 2 is 00,01,02,10,11,12,20,21,22.
REQ-026 Mid-frame sof:
- Stimulus: sof asserted with pix_valid=1 at row=2, col=3.
- Response: counters restart, no din_flag until the new row=2, col=2, then the full 6-window sequence.
REQ-027 Mid-frame reset:
- Stimulus: rst_n pulsed low asynchronously between clk edges at row=3.
- Response: all outputs read 0 before the next edge.
- Then: a following clean frame gives the REQ-023 results.
REQ-028 Default parameters, 640x480 frame: exactly 638*478=304964 din_flag pulses and one eof pulse.

Source files
------------

// File: rtl/window_3x3_gen_if.sv
// Pixel-stream and window bus for window_3x3_gen.
//   pix_in/pix_valid/sof : raster pixel input with start-of-frame marker
//   p1..p9               : 3x3 window, p1..p3 oldest row, p3/p6/p9 newest column
//   din_flag             : window on p1..p9 is valid this cycle
//   eof                  : one-cycle pulse after the last pixel of a frame
interface window_3x3_gen_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       din_flag;
  logic       eof;

  modport slave (
    input  pix_in, pix_valid, sof,
    output p1, p2, p3, p4, p5, p6, p7, p8, p9, din_flag, eof
  );

  modport master (
    output pix_in, pix_valid, sof,
    input  p1, p2, p3, p4, p5, p6, p7, p8, p9, din_flag, eof
  );
endinterface

// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two IMG_W-deep line buffers supply rows r-1 and r-2 of the current column; a 3x3 register
// array shifts left on every accepted pixel. All outputs are registered, one clk after accept.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   win_io : pixel input / window output bus (slave side)
module window_3x3_gen #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input logic              clk,
  input logic              rst_n,
  window_3x3_gen_if.slave  win_io
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d, eff_col;
  logic [RW-1:0] row_q, row_d, eff_row;
  logic          accept, last_col, last_row;
  logic          flag_d, eof_d;
  logic          din_flag_q, eof_q;
  logic [7:0]    lb1_rd, lb2_rd;

  // Line buffers carry no reset; stale data is harmless because row<2 gates din_flag.
  logic [7:0]    lb1_q [IMG_W];
  logic [7:0]    lb2_q [IMG_W];

  // Window registers, index 0..8 maps to p1..p9.
  logic [7:0]    p_q [9];

  always_comb begin
    accept   = win_io.pix_valid;
    // sof forces the current pixel to the frame origin regardless of counter state.
    eff_col  = win_io.sof ? '0 : col_q;
    eff_row  = win_io.sof ? '0 : row_q;
    last_col = (eff_col == CW'(IMG_W - 1));
    last_row = (eff_row == RW'(IMG_H - 1));
    lb1_rd   = lb1_q[eff_col];
    lb2_rd   = lb2_q[eff_col];

    col_d    = col_q;
    row_d    = row_q;
    flag_d   = 1'b0;
    eof_d    = 1'b0;
    if (accept) begin
      flag_d = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
      eof_d  = last_col && last_row;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
    end else if (win_io.sof) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      din_flag_q <= 1'b0;
      eof_q      <= 1'b0;
      for (int i = 0; i < 9; i++) p_q[i] <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      din_flag_q <= flag_d;
      eof_q      <= eof_d;
      if (accept) begin
        p_q[0] <= p_q[1];
        p_q[1] <= p_q[2];
        p_q[2] <= lb2_rd;
        p_q[3] <= p_q[4];
        p_q[4] <= p_q[5];
        p_q[5] <= lb1_rd;
        p_q[6] <= p_q[7];
        p_q[7] <= p_q[8];
        p_q[8] <= win_io.pix_in;
      end
    end
  end

  // Read-before-write: line-2 takes the old line-1 entry of this column.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[eff_col] <= win_io.pix_in;
      lb2_q[eff_col] <= lb1_rd;
    end
  end

  assign win_io.p1       = p_q[0];
  assign win_io.p2       = p_q[1];
  assign win_io.p3       = p_q[2];
  assign win_io.p4       = p_q[3];
  assign win_io.p5       = p_q[4];
  assign win_io.p6       = p_q[5];
  assign win_io.p7       = p_q[6];
  assign win_io.p8       = p_q[7];
  assign win_io.p9       = p_q[8];
  assign win_io.din_flag = din_flag_q;
  assign win_io.eof      = eof_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;
  localparam int W = 5;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_3x3_gen_if bus ();

  window_3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .win_io (bus)
  );

  typedef struct {
    bit          v;
    bit          s;
    logic [7:0]  px;
    bit          e_flag;
    bit          e_eof;
    logic [71:0] e_win;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: the frame as a 2D image plus a raster position.
  logic [7:0]  img [H][W];
  int          m_row, m_col;
  logic [71:0] m_win;
  bit          m_known;

  // Observed statistics.
  int          pulses, eofs;
  logic [71:0] first_win, last_win;
  bit          seen_first, last_eof;

  logic [71:0] first_ref, last_ref;

  function automatic logic [71:0] act_win();
    return {bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8, bus.p9};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    m_row = 0;
    m_col = 0;
    m_win = '0;
    m_known = 1'b1;
  endtask

  task automatic clear_stats();
    pulses = 0;
    eofs = 0;
    seen_first = 1'b0;
    last_eof = 1'b0;
    first_win = '0;
    last_win = '0;
  endtask

  // Drive one cycle, predict with the model, then check the registered response.
  task automatic step(input bit v, input bit s, input logic [7:0] px);
    int r, c;
    bit ef, ee;
    bus.pix_valid = v;
    bus.sof = s;
    bus.pix_in = px;
    r = s ? 0 : m_row;
    c = s ? 0 : m_col;
    ef = 1'b0;
    ee = 1'b0;
    if (v) begin
      img[r][c] = px;
      ef = (r >= 2) && (c >= 2);
      ee = (r == H - 1) && (c == W - 1);
      if (ef) begin
        m_win = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            m_win = {m_win[63:0], img[r - 2 + dr][c - 2 + dc]};
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
      if (c == W - 1) begin
        c = 0;
        r = (r == H - 1) ? 0 : r + 1;
      end else begin
        c = c + 1;
      end
      m_row = r;
      m_col = c;
    end else if (s) begin
      m_row = 0;
      m_col = 0;
    end
    @(posedge clk);
    #1;
    chk("din_flag", 72'(bus.din_flag), 72'(ef));
    chk("eof", 72'(bus.eof), 72'(ee));
    if (m_known) chk("window", act_win(), m_win);
    if (bus.din_flag) begin
      pulses++;
      if (!seen_first) first_win = act_win();
      seen_first = 1'b1;
      last_win = act_win();
      last_eof = bus.eof;
    end
    if (bus.eof) eofs++;
  endtask

  task automatic send_pixels(input int n, input bit first_sof, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) step(1'b0, 1'b0, 8'hee);
      step(1'b1, first_sof && (i == 0), 8'(((i / W) * 16) + (i % W)));
    end
  endtask

  task automatic check_frame(input string tag, input int exp_pulses);
    chk({tag, "_pulses"}, 72'(pulses), 72'(exp_pulses));
    chk({tag, "_first"}, first_win, first_ref);
  endtask

  vec_t vecs [W*H];

  initial begin
    first_ref = 72'h00_01_02_10_11_12_20_21_22;
    last_ref  = 72'h12_13_14_22_23_24_32_33_34;

    // Reference frame table: pix = row*16+col, window of three rows ending at (r,c).
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        vecs[r*W + c].v = 1'b1;
        vecs[r*W + c].s = (r == 0) && (c == 0);
        vecs[r*W + c].px = 8'(r * 16 + c);
        vecs[r*W + c].e_flag = (r >= 2) && (c >= 2);
        vecs[r*W + c].e_eof = (r == H - 1) && (c == W - 1);
        vecs[r*W + c].e_win = '0;
        if (r >= 2 && c >= 2)
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              vecs[r*W + c].e_win = {vecs[r*W + c].e_win[63:0],
                                     8'((r - 2 + dr) * 16 + (c - 2 + dc))};
      end
    end

    bus.pix_valid = 1'b0;
    bus.sof = 1'b0;
    bus.pix_in = 8'h00;
    reset_model();
    clear_stats();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flag", 72'(bus.din_flag), 72'd0);
    chk("rst_eof", 72'(bus.eof), 72'd0);
    chk("rst_window", act_win(), 72'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reference frame from the table.
    clear_stats();
    for (int i = 0; i < W*H; i++) begin
      step(vecs[i].v, vecs[i].s, vecs[i].px);
      chk("tbl_flag", 72'(bus.din_flag), 72'(vecs[i].e_flag));
      chk("tbl_eof", 72'(bus.eof), 72'(vecs[i].e_eof));
      if (vecs[i].e_flag) chk("tbl_window", act_win(), vecs[i].e_win);
    end
    check_frame("ref", 6);
    chk("ref_last", last_win, last_ref);
    chk("ref_last_eof", 72'(last_eof), 72'd1);
    chk("ref_eofs", 72'(eofs), 72'd1);

    // Same frame with a bubble before every pixel; window holds through bubbles.
    clear_stats();
    send_pixels(W*H, 1'b1, 1'b1);
    check_frame("gaps", 6);
    chk("gaps_last", last_win, last_ref);

    // Two back-to-back frames; the second starts without sof via counter wrap.
    clear_stats();
    send_pixels(W*H, 1'b1, 1'b0);
    seen_first = 1'b0;
    send_pixels(W*H, 1'b0, 1'b0);
    check_frame("b2b", 12);
    chk("b2b_eofs", 72'(eofs), 72'd2);

    // Mid-frame sof at row 2, col 3.
    send_pixels(13, 1'b1, 1'b0);
    clear_stats();
    send_pixels(W*H, 1'b1, 1'b0);
    check_frame("midsof", 6);
    chk("midsof_last", last_win, last_ref);

    // sof without pix_valid clears the counters.
    send_pixels(7, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h55);
    clear_stats();
    send_pixels(W*H, 1'b0, 1'b0);
    check_frame("idlesof", 6);

    // Asynchronous reset between edges at row 3.
    send_pixels(17, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_flag", 72'(bus.din_flag), 72'd0);
    chk("arst_eof", 72'(bus.eof), 72'd0);
    chk("arst_window", act_win(), 72'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    clear_stats();
    send_pixels(W*H, 1'b0, 1'b0);
    check_frame("arst", 6);
    chk("arst_last", last_win, last_ref);
    chk("arst_last_eof", 72'(last_eof), 72'd1);

    // Random traffic with bubbles and occasional sof against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
